// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmitter.
//   uart_tx_state_t : transmitter FSM state encoding (PARITY always present in
//                     the type; only reachable when UART_TX_PARITY_EN is set)
//   UART_DATA_W     : data bits per frame
//   clks_per_bit()  : bit period in core clocks (integer floor)
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam int UART_DATA_W = 8;

   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO that decouples the CPU write strobe from the baud rate.
// Ports:
//   clk   in   core clock
//   rstd  in   asynchronous active-low reset (empties the FIFO)
//   push  in   write din at the tail (ignored when full)
//   din   in   byte to store
//   pop   in   drop the head entry (ignored when empty)
//   dout  out  head of queue, combinational from the storage array
//   empty out  no entries held
//   full  out  DEPTH entries held
// -----------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rstd,
   input  logic                   push,
   input  logic [UART_DATA_W-1:0] din,
   input  logic                   pop,
   output logic [UART_DATA_W-1:0] dout,
   output logic                   empty,
   output logic                   full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [UART_DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [PTR_W:0]         r_count;

   logic w_push;
   logic w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (PTR_W+1)'(DEPTH));
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = r_mem[r_rd_ptr];

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Buffered serial transmitter: bytes written by the memory-access stage are
// queued in a FIFO and sent as 8N1 frames, LSB first, on the board TX pin.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
// Ports:
//   clk       in   core clock
//   rstd      in   asynchronous active-low reset
//   uart      in   byte to transmit
//   uart_we   in   write strobe, one byte accepted per cycle high
//   tx        out  serial line, idle high, driven from a register
//   busy      out  FIFO non-empty or frame in progress
//   fifo_full out  FIFO holds FIFO_DEPTH bytes
//   overflow  out  sticky: a write was dropped because the FIFO was full
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first, one bit period each
// PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); pops the next byte straight into START
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rstd,
   input  logic [UART_DATA_W-1:0] uart,
   input  logic                   uart_we,
   output logic                   tx,
   output logic                   busy,
   output logic                   fifo_full,
   output logic                   overflow
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_tx_state_t         r_state;
   logic [CNT_W-1:0]       r_baud_cnt;
   logic [2:0]             r_bit_idx;
   logic [UART_DATA_W-1:0] r_shift;
   logic                   r_tx;
   logic                   r_overflow;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity;
`endif

   logic                   w_baud_done;
   logic                   w_fifo_empty;
   logic                   w_fifo_full;
   logic [UART_DATA_W-1:0] w_fifo_dout;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_tx_next;

   // Full is sampled before the edge, so a same-cycle pop never makes room.
   assign w_push      = uart_we && !w_fifo_full;
   assign w_baud_done = (r_baud_cnt == CNT_LAST);
   assign w_pop       = !w_fifo_empty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstd  (rstd),
      .push  (w_push),
      .din   (uart),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

   // Line level for the current state; registered below so the pin is
   // glitch-free, which places tx one cycle behind the state register.
   always_comb begin
      w_tx_next = 1'b1;
      case (r_state)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_tx_next = r_parity;
`endif
         default: w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_tx <= w_tx_next;

         if (uart_we && w_fifo_full) begin
            r_overflow <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               r_baud_cnt <= '0;
               if (w_pop) begin
                  r_shift  <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^w_fifo_dout;
`endif
                  r_state  <= START;
               end
            end

            START: begin
               if (w_baud_done) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  r_state    <= DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (w_baud_done) begin
                  r_baud_cnt <= '0;
                  r_shift    <= r_shift >> 1;
                  r_bit_idx  <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_baud_done) begin
                  r_baud_cnt <= '0;
                  r_state    <= STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (w_baud_done) begin
                  r_baud_cnt <= '0;
                  // Chain straight into the next frame when data is waiting.
                  if (w_pop) begin
                     r_shift  <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                     r_parity <= ^w_fifo_dout;
`endif
                     r_state  <= START;
                  end else begin
                     r_state  <= IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            default: begin
               r_baud_cnt <= '0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign tx        = r_tx;
   assign busy      = (r_state != IDLE) || !w_fifo_empty;
   assign fifo_full = w_fifo_full;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx with CLK_FREQ=8, BAUD_RATE=1 (8 clocks/bit).
// A line monitor decodes frames off tx and compares them against a queue of
// expected bytes filled as writes are driven.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_CYC = 11 * CPB;
`else
   localparam int FRAME_CYC = 10 * CPB;
`endif

   logic       clk;
   logic       rstd;
   logic [7:0] uart;
   logic       uart_we;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         frames = 0;
   logic       mon_en = 1'b1;
   logic [7:0] sb[$];
   int         starts[$];

   uart_tx #(
      .CLK_FREQ   (8),
      .BAUD_RATE  (1),
      .FIFO_DEPTH (16)
   ) dut (
      .clk       (clk),
      .rstd      (rstd),
      .uart      (uart),
      .uart_we   (uart_we),
      .tx        (tx),
      .busy      (busy),
      .fifo_full (fifo_full),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Line monitor: detect the falling edge of a start bit, then sample each
   // bit in the middle of its period.
   initial begin : monitor
      logic       prev;
      logic       st;
      logic       sp;
      logic       par;
      logic [7:0] got;
      logic [7:0] exp;
      prev = 1'b1;
      par  = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mon_en && rstd === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
            starts.push_back(cyc);
            repeat (CPB/2) @(posedge clk);
            #1 st = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(posedge clk);
               #1 got[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(posedge clk);
            #1 par = tx;
`endif
            repeat (CPB) @(posedge clk);
            #1 sp = tx;
            frames++;
            checks++;
            if (st !== 1'b0) begin
               errors++;
               $display("FAIL frame_start: tx=%b expected 0", st);
            end
            checks++;
            if (sp !== 1'b1) begin
               errors++;
               $display("FAIL frame_stop: tx=%b expected 1", sp);
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected: got %h expected no frame", got);
            end else begin
               exp = sb.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL frame_data: got %h expected %h", got, exp);
               end
`ifdef UART_TX_PARITY_EN
               checks++;
               if (par !== ^exp) begin
                  errors++;
                  $display("FAIL frame_parity: got %b expected %b", par, ^exp);
               end
`endif
            end
            prev = sp;
         end else begin
            prev = tx;
         end
      end
   end

   // Called just after a posedge; the byte is sampled on the next posedge.
   task automatic write_byte(input logic [7:0] b, input bit expect_out);
      uart    = b;
      uart_we = 1'b1;
      if (expect_out) sb.push_back(b);
      @(posedge clk); #1;
      uart_we = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL %s_drain: %0d bytes pending busy=%b after %0d cycles", name, sb.size(), busy, n);
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rstd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      @(negedge clk) rstd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int n;
      write_byte(8'h55, 1'b1);
      @(posedge clk); #1;
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_latency1: tx=%b expected 1", tx); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      @(posedge clk); #1;
      checks++; if (tx !== 1'b0)   begin errors++; $display("FAIL single_latency2: tx=%b expected 0", tx); end
      n = 2;
      while (busy === 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != FRAME_CYC + 1) begin
         errors++;
         $display("FAIL single_busy_fall: at edge %0d expected %0d", n, FRAME_CYC + 1);
      end
      wait_drain("single", 200);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b expected 1", tx); end
   endtask

   task automatic test_back_to_back();
      starts.delete();
      write_byte(8'h00, 1'b1);
      write_byte(8'hFF, 1'b1);
      wait_drain("b2b", 400);
      checks++;
      if (starts.size() != 2) begin
         errors++;
         $display("FAIL b2b_frames: got %0d expected 2", starts.size());
      end else if (starts[1] - starts[0] != FRAME_CYC) begin
         errors++;
         $display("FAIL b2b_gap: got %0d expected %0d", starts[1] - starts[0], FRAME_CYC);
      end
   endtask

   task automatic test_overflow();
      int f0;
      logic [7:0] b;
      f0 = frames;
      for (int i = 1; i <= 17; i++) begin
         b = 8'(i);
         write_byte(b, 1'b1);
      end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      write_byte(8'h12, 1'b0);
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %b expected 1", fifo_full); end
      wait_drain("ovf", 3000);
      checks++;
      if (frames - f0 != 17) begin
         errors++;
         $display("FAIL ovf_frames: got %0d expected 17", frames - f0);
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", overflow); end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      mon_en = 1'b0;
      write_byte(8'hA5, 1'b0);
      repeat (30) @(posedge clk);
      #2 rstd = 1'b0;
      #1;
      checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b expected 0", overflow); end
      repeat (2) @(posedge clk);
      @(negedge clk) rstd = 1'b1;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rstmid_quiet: %0d active cycles expected 0", bad);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_push_pop();
      starts.delete();
      write_byte(8'h11, 1'b1);
      write_byte(8'h22, 1'b1);
      write_byte(8'h33, 1'b1);
      write_byte(8'h44, 1'b1);
      // First frame entered START one edge after its write; its STOP ends and
      // pops the next byte 80 edges after that.
      repeat (FRAME_CYC - 3) @(posedge clk);
      #1;
      checks++;
      if (dut.u_fifo.r_count !== 5'd3) begin
         errors++;
         $display("FAIL pushpop_before: count %0d expected 3", dut.u_fifo.r_count);
      end
      write_byte(8'h5A, 1'b1);
      checks++;
      if (dut.u_fifo.r_count !== 5'd3) begin
         errors++;
         $display("FAIL pushpop_after: count %0d expected 3", dut.u_fifo.r_count);
      end
      wait_drain("pushpop", 800);
      checks++;
      if (starts.size() != 5) begin
         errors++;
         $display("FAIL pushpop_frames: got %0d expected 5", starts.size());
      end else if (starts[1] - starts[0] != FRAME_CYC) begin
         errors++;
         $display("FAIL pushpop_gap: got %0d expected %0d", starts[1] - starts[0], FRAME_CYC);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      starts.delete();
      write_byte(8'h07, 1'b1);
      write_byte(8'h03, 1'b1);
      wait_drain("parity", 400);
      checks++;
      if (starts.size() != 2) begin
         errors++;
         $display("FAIL parity_frames: got %0d expected 2", starts.size());
      end else if (starts[1] - starts[0] != 88) begin
         errors++;
         $display("FAIL parity_frame_len: got %0d expected 88", starts[1] - starts[0]);
      end
   endtask
`endif

   initial begin
      rstd    = 1'b1;
      uart    = 8'h00;
      uart_we = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      test_push_pop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d bytes expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
